// File: rtl/kyber_pkg.sv
// Shared definitions for the encrypt_engine slice: default ring parameters,
// coefficient/noise types, the QHALF helper and the engine state encoding.
package kyber_pkg;

  localparam int K_DEF  = 2;
  localparam int N_DEF  = 4;
  localparam int Q_DEF  = 17;
  localparam int CW_DEF = $clog2(Q_DEF);

  typedef logic [CW_DEF-1:0] coeff_t;
  typedef logic signed [1:0] noise_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC_U,
    MAC_V,
    FINAL,
    DONE
  } state_t;

  // Rounded half of the modulus, used to lift a message bit into Z_Q.
  function automatic int qhalf(input int q);
    return (q + 1) / 2;
  endfunction

endpackage

// File: rtl/mod_q_reduce.sv
// Combinational reduction of a signed accumulator value into [0, Q-1].
module mod_q_reduce #(
  parameter int Q     = 17,
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0]   x,
  output logic        [$clog2(Q)-1:0] y
);

  localparam int CW = $clog2(Q);
  localparam logic signed [ACC_W-1:0] QS = ACC_W'(Q);

  logic signed [ACC_W-1:0] rem;

  // Signed remainder takes the sign of x, so fold negative results up by Q.
  always_comb begin
    rem = x % QS;
    if (rem < 0) rem = rem + QS;
    y = CW'(rem);
  end

endmodule

// File: rtl/encrypt_engine.sv
// Sequential Kyber-style encryption core over Z_Q[x]/(x^N+1).
// One coefficient product per cycle: first u = A^T * r, then v' = t^T * r,
// then a single finalisation cycle adds noise/message and reduces mod Q.
// Optional feature macro: NOISE_LFSR_EN (internal LFSR noise source instead
// of the r_vec/e1_vec/e2_vec ports).
module encrypt_engine
  import kyber_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int ACC_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          in_ready,
  input  logic [N-1:0]                  message,
  input  logic [K*K*N*$clog2(Q)-1:0]    a_mat,
  input  logic [K*N*$clog2(Q)-1:0]      t_vec,
  input  logic [K*N*2-1:0]              r_vec,
  input  logic [K*N*2-1:0]              e1_vec,
  input  logic [N*2-1:0]                e2_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [K*N*$clog2(Q)-1:0]      u_out,
  output logic [N*$clog2(Q)-1:0]        v_out
);

  localparam int CW = $clog2(Q);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int QH = qhalf(Q);

  state_t state, state_nx;

  logic [N-1:0]           msg_r;
  logic [K*K*N*CW-1:0]    a_r;
  logic [K*N*CW-1:0]      t_r;
  logic [K*N*2-1:0]       r_r;
  logic [K*N*2-1:0]       e1_r;
  logic [N*2-1:0]         e2_r;

  logic signed [ACC_W-1:0] acc_u [K][N];
  logic signed [ACC_W-1:0] acc_v [N];

  logic [KW-1:0] cnt_i, cnt_k;
  logic [NW-1:0] cnt_m, cnt_n;
  logic n_last, m_last, k_last, i_last, u_last, v_last;

  int ki, ii, mi, ni, tgt;
  logic [CW-1:0]           coef;
  logic [1:0]              nz;
  logic signed [ACC_W-1:0] prod, term;

  logic [K*N*CW-1:0] red_u;
  logic [N*CW-1:0]   red_v;

  function automatic logic signed [ACC_W-1:0] sext2(input noise_t b);
    return ACC_W'(b);
  endfunction

  assign n_last = (cnt_n == NW'(N - 1));
  assign m_last = (cnt_m == NW'(N - 1));
  assign k_last = (cnt_k == KW'(K - 1));
  assign i_last = (cnt_i == KW'(K - 1));
  assign v_last = n_last && m_last && k_last;
  assign u_last = v_last && i_last;

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; start/out_ready only matter in IDLE/DONE.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) state_nx = LOAD;
      end
      LOAD:  state_nx = MAC_U;
      MAC_U: if (u_last) state_nx = MAC_V;
      MAC_V: if (v_last) state_nx = FINAL;
      FINAL: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Select this cycle's operands and fold the negacyclic wrap into the sign.
  always_comb begin
    ki   = int'(cnt_k);
    ii   = int'(cnt_i);
    mi   = int'(cnt_m);
    ni   = int'(cnt_n);
    if (state == MAC_V) coef = t_r[(ki*N + mi)*CW +: CW];
    else                coef = a_r[((ki*K + ii)*N + mi)*CW +: CW];
    nz   = r_r[(ki*N + ni)*2 +: 2];
    prod = ACC_W'(coef) * sext2(nz);
    if (mi + ni >= N) begin
      tgt  = mi + ni - N;
      term = -prod;
    end else begin
      tgt  = mi + ni;
      term = prod;
    end
  end

  // Operand capture on the accept edge, accumulation, counters and result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_r <= '0;
      a_r   <= '0;
      t_r   <= '0;
      cnt_i <= '0;
      cnt_k <= '0;
      cnt_m <= '0;
      cnt_n <= '0;
      u_out <= '0;
      v_out <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < N; j++) acc_u[i][j] <= '0;
      for (int j = 0; j < N; j++) acc_v[j] <= '0;
    end else begin
      if (state == IDLE && start) begin
        msg_r <= message;
        a_r   <= a_mat;
        t_r   <= t_vec;
      end
      if (state == LOAD) begin
        cnt_i <= '0;
        cnt_k <= '0;
        cnt_m <= '0;
        cnt_n <= '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < N; j++) acc_u[i][j] <= '0;
        for (int j = 0; j < N; j++) acc_v[j] <= '0;
      end
      if (state == MAC_U || state == MAC_V) begin
        cnt_n <= n_last ? '0 : cnt_n + 1'b1;
        if (n_last) cnt_m <= m_last ? '0 : cnt_m + 1'b1;
        if (n_last && m_last) cnt_k <= k_last ? '0 : cnt_k + 1'b1;
      end
      if (state == MAC_U) begin
        if (v_last) cnt_i <= i_last ? '0 : cnt_i + 1'b1;
        acc_u[ii][tgt] <= acc_u[ii][tgt] + term;
      end
      if (state == MAC_V) acc_v[tgt] <= acc_v[tgt] + term;
      if (state == FINAL) begin
        u_out <= red_u;
        v_out <= red_v;
      end
    end
  end

`ifdef NOISE_LFSR_EN
  localparam int NS = 2*K*N + N;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [31:0]     lfsr;
  logic [2*NS-1:0] lfsr_noise;

  // Map 2-bit LFSR slices (wrapping around the 32-bit state) to {-1,0,1}.
  always_comb begin
    lfsr_noise = '0;
    for (int s = 0; s < NS; s++) begin
      case (lfsr[(2*s) % 32 +: 2])
        2'b01:   lfsr_noise[2*s +: 2] = 2'b01;
        2'b10:   lfsr_noise[2*s +: 2] = 2'b11;
        default: lfsr_noise[2*s +: 2] = 2'b00;
      endcase
    end
  end

  // Galois LFSR, stepped once per encryption while in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                lfsr <= 32'hACE1_2024;
    else if (state == LOAD) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  end

  // Noise registers take the mapped LFSR slices during LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r  <= '0;
      e1_r <= '0;
      e2_r <= '0;
    end else if (state == LOAD) begin
      r_r  <= lfsr_noise[0 +: 2*K*N];
      e1_r <= lfsr_noise[2*K*N +: 2*K*N];
      e2_r <= lfsr_noise[4*K*N +: 2*N];
    end
  end
`else
  // Noise registers take the port values together with the other operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r  <= '0;
      e1_r <= '0;
      e2_r <= '0;
    end else if (state == IDLE && start) begin
      r_r  <= r_vec;
      e1_r <= e1_vec;
      e2_r <= e2_vec;
    end
  end
`endif

  for (genvar gi = 0; gi < K; gi++) begin : g_u_row
    for (genvar gj = 0; gj < N; gj++) begin : g_u_col
      logic signed [ACC_W-1:0] sum;
      logic [CW-1:0]           red;
      assign sum = acc_u[gi][gj] + sext2(e1_r[(gi*N + gj)*2 +: 2]);
      mod_q_reduce #(.Q(Q), .ACC_W(ACC_W)) u_red (.x(sum), .y(red));
      assign red_u[(gi*N + gj)*CW +: CW] = red;
    end
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_v
    logic signed [ACC_W-1:0] sum;
    logic [CW-1:0]           red;
    assign sum = acc_v[gj] + sext2(e2_r[gj*2 +: 2]) + (msg_r[gj] ? ACC_W'(QH) : '0);
    mod_q_reduce #(.Q(Q), .ACC_W(ACC_W)) u_red (.x(sum), .y(red));
    assign red_v[gj*CW +: CW] = red;
  end

endmodule

// File: tb/tb_encrypt_engine.sv
// Self-checking bench for encrypt_engine: table of directed vectors with
// hand-computed ciphertexts, plus handshake, mid-operation reset and a
// K=3/N=8 latency instance.
module tb_encrypt_engine;

  localparam int K  = 2;
  localparam int N  = 4;
  localparam int Q  = 17;
  localparam int CW = 5;
  localparam int BK = 3;
  localparam int BN = 8;

  logic clk = 1'b0;
  logic rst, start, in_ready, out_valid, out_ready;
  logic [N-1:0]        message;
  logic [K*K*N*CW-1:0] a_mat;
  logic [K*N*CW-1:0]   t_vec;
  logic [K*N*2-1:0]    r_vec, e1_vec;
  logic [N*2-1:0]      e2_vec;
  logic [K*N*CW-1:0]   u_out;
  logic [N*CW-1:0]     v_out;

  logic big_start, big_in_ready, big_out_valid, big_out_ready;
  logic [BN-1:0]          big_msg = '0;
  logic [BK*BK*BN*CW-1:0] big_a   = '0;
  logic [BK*BN*CW-1:0]    big_t   = '0;
  logic [BK*BN*2-1:0]     big_r   = '0;
  logic [BK*BN*2-1:0]     big_e1  = '0;
  logic [BN*2-1:0]        big_e2  = '0;
  logic [BK*BN*CW-1:0]    big_u;
  logic [BN*CW-1:0]       big_v;

  int errors = 0;
  int checks = 0;
  int lat;

  typedef struct packed {
    logic [3:0]  msg;
    logic [79:0] a;
    logic [39:0] t;
    logic [15:0] r;
    logic [15:0] e1;
    logic [7:0]  e2;
    logic [39:0] eu;
    logic [19:0] ev;
  } vec_t;

  vec_t tv [5];

  always #5 clk = ~clk;

  encrypt_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .message(message), .a_mat(a_mat), .t_vec(t_vec),
    .r_vec(r_vec), .e1_vec(e1_vec), .e2_vec(e2_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .u_out(u_out), .v_out(v_out)
  );

  encrypt_engine #(.K(BK), .N(BN), .Q(Q), .ACC_W(32)) dut_big (
    .clk(clk), .rst(rst), .start(big_start), .in_ready(big_in_ready),
    .message(big_msg), .a_mat(big_a), .t_vec(big_t),
    .r_vec(big_r), .e1_vec(big_e1), .e2_vec(big_e2),
    .out_valid(big_out_valid), .out_ready(big_out_ready),
    .u_out(big_u), .v_out(big_v)
  );

  task automatic setA(input int v, input int k, input int i, input int m, input int val);
    tv[v].a[((k*K + i)*N + m)*CW +: CW] = CW'(val);
  endtask
  task automatic setT(input int v, input int k, input int m, input int val);
    tv[v].t[(k*N + m)*CW +: CW] = CW'(val);
  endtask
  task automatic setR(input int v, input int k, input int n, input int val);
    tv[v].r[(k*N + n)*2 +: 2] = 2'(val);
  endtask
  task automatic setE1(input int v, input int i, input int j, input int val);
    tv[v].e1[(i*N + j)*2 +: 2] = 2'(val);
  endtask
  task automatic setE2(input int v, input int j, input int val);
    tv[v].e2[j*2 +: 2] = 2'(val);
  endtask
  task automatic expU(input int v, input int i, input int j, input int val);
    tv[v].eu[(i*N + j)*CW +: CW] = CW'(val);
  endtask
  task automatic expV(input int v, input int j, input int val);
    tv[v].ev[j*CW +: CW] = CW'(val);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one request, scramble inputs after acceptance, poke ignored
  // start/out_ready pulses while busy, and count edges until out_valid.
  task automatic applyStimulus(input vec_t v, input string tag, output int edges);
    message = v.msg;
    a_mat   = v.a;
    t_vec   = v.t;
    r_vec   = v.r;
    e1_vec  = v.e1;
    e2_vec  = v.e2;
    start   = 1'b1;
    checkOutput({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
    message = 4'($urandom());
    a_mat   = 80'({$urandom(), $urandom(), $urandom()});
    t_vec   = 40'({$urandom(), $urandom()});
    r_vec   = 16'($urandom());
    e1_vec  = 16'($urandom());
    e2_vec  = 8'($urandom());
    edges = 0;
    while (!out_valid && edges < 2000) begin
      out_ready = (edges % 7 == 3);
      start     = (edges % 13 == 5);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  // Check the result, its stability while the consumer stalls, and the return to IDLE.
  task automatic finishTransaction(input vec_t v, input string tag);
    logic ok;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_u"}, 64'(u_out), 64'(v.eu));
    checkOutput({tag, "_v"}, 64'(v_out), 64'(v.ev));
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || u_out !== v.eu || v_out !== v.ev) ok = 1'b0;
    end
    start = 1'b0;
    checkOutput({tag, "_hold"}, 64'(ok), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
    checkOutput({tag, "_keep"}, 64'({u_out, v_out}), 64'({v.eu, v.ev}));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) tv[i] = '0;
    // Message lift only: v = {0,9,0,9}.
    tv[0].msg = 4'b1010;
    expV(0, 1, 9); expV(0, 3, 9);
    // x * x^3 = x^4 = -1 in the negacyclic ring.
    setA(1, 0, 0, 1, 1); setR(1, 0, 3, 1);
    expU(1, 0, 0, 16);
    // Noise only.
    setE1(2, 0, 0, -1); setE1(2, 0, 1, 1); setE2(2, 2, -1); setE2(2, 3, -1);
    expU(2, 0, 0, 16); expU(2, 0, 1, 1); expV(2, 2, 16); expV(2, 3, 16);
    // (3+2x^3)(x-1), 5x^2(x-1), (1+x^2)(x-1) plus message/noise.
    setA(3, 1, 0, 0, 3); setA(3, 1, 0, 3, 2); setA(3, 1, 1, 2, 5);
    setR(3, 1, 0, -1); setR(3, 1, 1, 1);
    setT(3, 1, 0, 1); setT(3, 1, 2, 1);
    tv[3].msg = 4'b0001; setE2(3, 3, 1); setE1(3, 1, 2, -1);
    expU(3, 0, 0, 12); expU(3, 0, 1, 3); expU(3, 0, 3, 15);
    expU(3, 1, 2, 11); expU(3, 1, 3, 5);
    expV(3, 0, 8); expV(3, 1, 1); expV(3, 2, 16); expV(3, 3, 2);
    // Maximum coefficients with wrap and mixed noise.
    for (int m = 0; m < 4; m++) setA(4, 0, 0, m, 16);
    setR(4, 0, 1, 1); setE1(4, 0, 0, -1);
    for (int j = 0; j < 4; j++) setE1(4, 1, j, 1);
    setT(4, 0, 0, 16); tv[4].msg = 4'b1111;
    setE2(4, 0, 1); setE2(4, 1, -1); setE2(4, 2, 1); setE2(4, 3, -1);
    expU(4, 0, 1, 16); expU(4, 0, 2, 16); expU(4, 0, 3, 16);
    for (int j = 0; j < 4; j++) expU(4, 1, j, 1);
    expV(4, 0, 10); expV(4, 1, 7); expV(4, 2, 10); expV(4, 3, 8);

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    message = '0; a_mat = '0; t_vec = '0; r_vec = '0; e1_vec = '0; e2_vec = '0;
    big_start = 1'b0; big_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_u", 64'(u_out), 64'd0);
    checkOutput("reset_v", 64'(v_out), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(tv[i], $sformatf("vec%0d", i), lat);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd98);
      finishTransaction(tv[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of MAC_U, then the same request again.
    message = tv[3].msg; a_mat = tv[3].a; t_vec = tv[3].t;
    r_vec = tv[3].r; e1_vec = tv[3].e1; e2_vec = tv[3].e2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_u", 64'(u_out), 64'd0);
    checkOutput("midrst_v", 64'(v_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(tv[3], "after_rst", lat);
    checkOutput("after_rst_latency", 64'(lat), 64'd98);
    finishTransaction(tv[3], "after_rst");

    // Larger configuration: latency only, all-zero operands.
    big_start = 1'b1;
    checkOutput("big_accept_ready", 64'(big_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    big_start = 1'b0;
    lat = 0;
    while (!big_out_valid && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("big_latency", 64'(lat), 64'd770);
    checkOutput("big_zero", 64'({|big_u, |big_v}), 64'd0);
    big_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    big_out_ready = 1'b0;
    checkOutput("big_idle", 64'({big_in_ready, big_out_valid}), 64'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encrypt_engine.md
ENCRYPT_ENGINE -- requirements
Module: encrypt_engine

Interface
REQ-001 SHALL have parameter K, 2, module rank (number of polynomials per vector).
REQ-002 SHALL have parameter N, 4, polynomial degree; ring is Z_Q[x]/(x^N+1).
REQ-003 SHALL have parameter Q, 17, coefficient modulus (odd, >= 3).
REQ-004 SHALL have parameter ACC_W, 32, signed accumulator width.
REQ-005 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start input 1: request; accepted only when in_ready=1.
REQ-008 SHALL have port in_ready output 1: high only in IDLE.
REQ-009 SHALL have port message input N: bit i is the plaintext bit for coefficient i.
REQ-010 SHALL have port a_mat input K*K*N*$clog2(Q): matrix A, coefficients in [0,Q-1].
REQ-011 SHALL have port t_vec input K*N*$clog2(Q): public vector t.
REQ-012 SHALL have port r_vec, e1_vec input K*N*2 each, plus e2_vec input N*2: signed noise in {-1,0,1}.
REQ-013 SHALL have port out_valid output 1 and out_ready input 1: result handshake.
REQ-014 SHALL have port u_out output K*N*$clog2(Q) and v_out output N*$clog2(Q): ciphertext, coefficients in [0,Q-1].

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> MAC_U -> MAC_V -> FINAL -> DONE -> IDLE.
REQ-016 IDLE: start=1 at an edge SHALL move to LOAD; LOAD SHALL register message, a_mat, t_vec and noise (1 cycle).
REQ-017 MAC_U SHALL perform exactly one coefficient product per cycle, K*K*N*N cycles, computing u[i] = sum_k A[k][i]*r[k] (A transposed).
REQ-018 MAC_V SHALL perform one product per cycle, K*N*N cycles, computing v' = sum_k t[k]*r[k].
REQ-019 Product a[m]*r[n] SHALL accumulate into index (m+n) mod N, negated when m+n >= N.
REQ-020 FINAL (1 cycle) SHALL set u[i][j] = mod(acc_u + e1[i][j]) and v[j] = mod(acc_v + e2[j] + message[j]*QHALF), QHALF=(Q+1)/2, mod(x) = ((x % Q)+Q) % Q.
REQ-021 DONE SHALL hold out_valid=1 and u_out/v_out stable until out_ready=1; handshake edge returns to IDLE.
REQ-022 Latency SHALL be exactly 2+K*K*N*N+K*N*N edges from the start-accept edge to out_valid high (98 for defaults).
REQ-023 start while not IDLE SHALL be ignored; out_ready while out_valid=0 SHALL be ignored.
REQ-024 u_out/v_out SHALL update only in FINAL; they hold the previous result in all other states.
REQ-025 Accumulators SHALL be cleared in LOAD; inputs may change after the accept edge without effect.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, u_out=0, v_out=0, accumulators and counters 0, including mid-operation.
REQ-027 First start SHALL be accepted at the first edge after rst deasserts.

Configuration
REQ-028 With NOISE_LFSR_EN defined, r/e1/e2 SHALL come from an internal 32-bit Galois LFSR (seed 32'hACE1_2024 on reset, advanced in LOAD only), mapping 2-bit slices 00->0, 01->1, 10->-1, 11->0; noise ports ignored.
REQ-029 Without NOISE_LFSR_EN, noise SHALL come from r_vec/e1_vec/e2_vec registered in LOAD; no LFSR logic present.

Structure
REQ-030 Package kyber_pkg SHALL hold default K/N/Q, QHALF function, coefficient/noise typedefs and FSM state enum.
REQ-031 Sub-module mod_q_reduce (combinational, parametrised Q, ACC_W) SHALL implement mod(); FINAL instantiates it per coefficient.

Verification
REQ-032 A=0, t=0, noise=0, message=4'b1010 -> u_out all 0, v_out={0,9,0,9} (index 0..3).
REQ-033 A[0][0]=x, r[0]=x^3, others 0 -> u[0]={16,0,0,0} (negacyclic wrap), u[1]=0.
REQ-034 A=0, e1[0]={-1,1,0,0}, e2={0,0,-1,-1}, message=0 -> u[0]={16,1,0,0}, v={0,0,16,16}.
REQ-035 Defaults: out_valid exactly 98 edges after accept; K=3,N=8 -> 770; start pulses while busy ignored.
REQ-036 out_ready low 10 cycles in DONE -> out_valid and outputs stable; ready edge -> IDLE next cycle.
REQ-037 rst asserted at MAC_U cycle 30 -> all outputs 0, in_ready=1; next start yields correct result.
